// File: rtl/store_drain_ctrl_if.sv
// Store/load/memory-side signals of the store drain controller.
// slave: the controller; master: the pipeline and memory side driving it.
interface store_drain_ctrl_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_byteen;
  logic        st_stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_ack;
  logic        bus_err;
  logic        idle;

  modport slave (
    input  st_valid, st_addr, st_data, st_byteen, ld_valid, ld_addr, m_ack,
    output st_stall, ld_hazard, m_req, m_addr, m_wdata, m_byteen, bus_err, idle
  );

  modport master (
    output st_valid, st_addr, st_data, st_byteen, ld_valid, ld_addr, m_ack,
    input  st_stall, ld_hazard, m_req, m_addr, m_wdata, m_byteen, bus_err, idle
  );
endinterface

// File: rtl/store_drain_ctrl.sv
// In-order store queue between M stage and the data-memory bus.
// Stores are lane-replicated on entry, drained one at a time over req/ack,
// and a hung write is dropped after TIMEOUT busy cycles with a bus_err pulse.
module store_drain_ctrl #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  store_drain_ctrl_if.slave bus
);
  localparam int WCNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [29:0]       entAddr [DEPTH];
  logic [31:0]       entData [DEPTH];
  logic [3:0]        entBe   [DEPTH];
  logic [PTR_W-1:0]  rdPtr, wrPtr, hzOff;
  logic [PTR_W:0]    count, countNext;
  logic [WCNT_W-1:0] waitCnt;
  logic              busErr, full, push, pop, timeoutHit, hzAny;
  logic [31:0]       pushData;
  logic              unusedAddrLow;

  // Word address only matters; the byte offset lives in the byte enables.
  assign unusedAddrLow = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // Full stalls regardless of a same-cycle pop: keeps the stall path short.
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign push       = bus.st_valid && (bus.st_byteen != 4'b0000) && !full;
  assign timeoutHit = (waitCnt == WCNT_W'(TIMEOUT - 1));
  assign pop        = (state == BUSY) && (bus.m_ack || timeoutHit);
  assign countNext  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // Replicate narrow store data onto every lane its enables may select.
  always_comb begin
    pushData = bus.st_data;
    case (bus.st_byteen)
      4'b0011, 4'b1100:                   pushData = {2{bus.st_data[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: pushData = {4{bus.st_data[7:0]}};
      default:                            pushData = bus.st_data;
    endcase
  end

  // Entry storage; validity is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      entAddr[wrPtr] <= bus.st_addr[31:2];
      entData[wrPtr] <= pushData;
      entBe[wrPtr]   <= bus.st_byteen;
    end
  end

  // Queue pointers, occupancy, drain FSM, watchdog and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count  <= countNext;
      busErr <= pop && !bus.m_ack;
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (count != '0) state <= BUSY;
        end
        BUSY: begin
          if (pop) begin
            waitCnt <= '0;
            state   <= (countNext != '0) ? BUSY : IDLE;
          end else begin
            waitCnt <= waitCnt + WCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load conflicts with any live entry, including the one in flight.
  always_comb begin
    hzAny = 1'b0;
    hzOff = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hzOff = PTR_W'(i) - rdPtr;
      if (({1'b0, hzOff} < count) && (entAddr[i] == bus.ld_addr[31:2]))
        hzAny = 1'b1;
    end
  end

  assign bus.ld_hazard = bus.ld_valid && hzAny;
  assign bus.st_stall  = full;
  assign bus.m_req     = (state == BUSY);
  assign bus.m_addr    = (state == BUSY) ? {entAddr[rdPtr], 2'b00} : 32'h0;
  assign bus.m_wdata   = (state == BUSY) ? entData[rdPtr] : 32'h0;
  assign bus.m_byteen  = (state == BUSY) ? entBe[rdPtr] : 4'h0;
  assign bus.bus_err   = busErr;
  assign bus.idle      = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_store_drain_ctrl.sv
// Bench for store_drain_ctrl: a negedge scoreboard tracks accepted stores,
// checks every drained beat, stall and hazard; directed sequences cover timing.
module tb_store_drain_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_drain_ctrl_if sdIf();

  store_drain_ctrl #(.DEPTH(DEPTH), .PTR_W(2), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sdIf.slave)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] expW;
  } vec_t;

  exp_t sb[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   wcnt = 0;
  logic monHz;
  bit   monFull;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] repl(input logic [3:0] be, input logic [31:0] d);
    case (be)
      4'b0011, 4'b1100:                   return {2{d[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {4{d[7:0]}};
      default:                            return d;
    endcase
  endfunction

  // Scoreboard: sample just before the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      wcnt = 0;
    end else begin
      monFull = (sb.size() == DEPTH);
      chkb("st_stall", sdIf.st_stall, monFull);
      monHz = 1'b0;
      foreach (sb[i]) if (sb[i].addr == sdIf.ld_addr[31:2]) monHz = 1'b1;
      chkb("ld_hazard", sdIf.ld_hazard, sdIf.ld_valid && monHz);
      if (sdIf.m_req) begin
        if (sb.size() == 0) begin
          totalCnt++;
          $display("FAIL spurious_m_req: got m_req=1, expected 0 with nothing queued");
        end else begin
          chk("m_addr", sdIf.m_addr, {sb[0].addr, 2'b00});
          chk("m_wdata", sdIf.m_wdata, sb[0].data);
          chk("m_byteen", {28'h0, sdIf.m_byteen}, {28'h0, sb[0].be});
          if (sdIf.m_ack || wcnt == TIMEOUT - 1) begin
            void'(sb.pop_front());
            wcnt = 0;
          end else wcnt++;
        end
      end
      if (sdIf.st_valid && sdIf.st_byteen != 4'b0000 && !monFull)
        sb.push_back({sdIf.st_addr[31:2], repl(sdIf.st_byteen, sdIf.st_data), sdIf.st_byteen});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish within 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sdIf.st_valid  = 1'b1;
    sdIf.st_addr   = a;
    sdIf.st_data   = d;
    sdIf.st_byteen = be;
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n = 0;
    while (!sdIf.idle && n < maxCyc) begin
      tick();
      n++;
    end
    #1;
    chkb(name, sdIf.idle, 1'b1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b1111, 32'hA1B2C3D4, 32'hA1B2C3D4};
    vecs[1] = '{4'b0011, 32'hA1B2C3D4, 32'hC3D4C3D4};
    vecs[2] = '{4'b1100, 32'hA1B2C3D4, 32'hC3D4C3D4};
    vecs[3] = '{4'b0001, 32'hA1B2C3D4, 32'hD4D4D4D4};
    vecs[4] = '{4'b0100, 32'hA1B2C3D4, 32'hD4D4D4D4};
    vecs[5] = '{4'b0101, 32'hA1B2C3D4, 32'hA1B2C3D4};
    vecs[6] = '{4'b1110, 32'hA1B2C3D4, 32'hA1B2C3D4};

    sdIf.st_valid = 0; sdIf.st_addr = 0; sdIf.st_data = 0; sdIf.st_byteen = 0;
    sdIf.ld_valid = 0; sdIf.ld_addr = 0; sdIf.m_ack = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chkb("rst m_req", sdIf.m_req, 1'b0);
    chkb("rst st_stall", sdIf.st_stall, 1'b0);
    chkb("rst ld_hazard", sdIf.ld_hazard, 1'b0);
    chkb("rst idle", sdIf.idle, 1'b1);
    chkb("rst bus_err", sdIf.bus_err, 1'b0);
    chk("rst m_addr", sdIf.m_addr, 32'h0);
    chk("rst m_wdata", sdIf.m_wdata, 32'h0);
    chk("rst m_byteen", {28'h0, sdIf.m_byteen}, 32'h0);
    tick();
    rst_n = 1'b1;

    // sw into empty queue, ack after 3 wait cycles
    tick();
    drv(32'h1004, 32'hDEADBEEF, 4'b1111);
    #1 chkb("sw idle before", sdIf.idle, 1'b1);
    tick();
    sdIf.st_valid = 0;
    #1 chkb("sw m_req push cycle", sdIf.m_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) sdIf.m_ack = 1'b1;
      #1;
      chkb("sw m_req", sdIf.m_req, 1'b1);
      chk("sw m_addr", sdIf.m_addr, 32'h1004);
      chk("sw m_wdata", sdIf.m_wdata, 32'hDEADBEEF);
      chk("sw m_byteen", {28'h0, sdIf.m_byteen}, 32'hF);
    end
    tick();
    sdIf.m_ack = 1'b0;
    #1 chkb("sw idle after ack", sdIf.idle, 1'b1);
    chkb("sw m_req after ack", sdIf.m_req, 1'b0);

    // sb then sh, ack tied high: back-to-back beats
    sdIf.m_ack = 1'b1;
    tick();
    drv(32'h2003, 32'h12345678, 4'b1000);
    tick();
    drv(32'h2002, 32'h12345678, 4'b1100);
    tick();
    sdIf.st_valid = 0;
    #1 chk("sb m_wdata", sdIf.m_wdata, 32'h78787878);
    chk("sb m_byteen", {28'h0, sdIf.m_byteen}, 32'h8);
    tick();
    #1 chk("sh m_wdata", sdIf.m_wdata, 32'h56785678);
    chk("sh m_byteen", {28'h0, sdIf.m_byteen}, 32'hC);
    tick();
    #1 chkb("sbsh idle", sdIf.idle, 1'b1);

    // Replication table
    for (int i = 0; i < 7; i++) begin
      tick();
      drv(32'h5000 + 32'(i) * 4, vecs[i].data, vecs[i].be);
      tick();
      sdIf.st_valid = 0;
      tick();
      #1 chkb("tbl m_req", sdIf.m_req, 1'b1);
      chk("tbl m_wdata", sdIf.m_wdata, vecs[i].expW);
      chk("tbl m_byteen", {28'h0, sdIf.m_byteen}, {28'h0, vecs[i].be});
      tick();
      #1 chkb("tbl idle", sdIf.idle, 1'b1);
    end
    sdIf.m_ack = 1'b0;

    // Byte enable 0000 is not a write
    tick();
    drv(32'h6000, 32'h11111111, 4'b0000);
    tick();
    tick();
    sdIf.st_valid = 0;
    #1 chkb("be0 idle", sdIf.idle, 1'b1);
    chkb("be0 m_req", sdIf.m_req, 1'b0);

    // Full queue: 5th store held until one ack, then wraps in order
    for (int i = 0; i < 5; i++) begin
      tick();
      drv(32'h4000 + 32'(i) * 4, 32'hC0DE0000 + 32'(i), 4'b1111);
    end
    #1 chkb("full stall after 4", sdIf.st_stall, 1'b1);
    tick();
    #1 chkb("full 5th held", sdIf.st_stall, 1'b1);
    sdIf.m_ack = 1'b1;
    tick();
    sdIf.m_ack = 1'b0;
    #1 chkb("full stall cleared", sdIf.st_stall, 1'b0);
    tick();
    sdIf.st_valid = 0;
    #1 chkb("full 5th entered", sdIf.st_stall, 1'b1);
    chk("full head addr", sdIf.m_addr, 32'h4004);
    sdIf.m_ack = 1'b1;
    waitIdle("full drain idle", 20);
    sdIf.m_ack = 1'b0;

    // Load hazard on word address
    tick();
    drv(32'h3008, 32'hCAFEF00D, 4'b1111);
    tick();
    sdIf.st_valid = 0;
    sdIf.ld_valid = 1;
    sdIf.ld_addr  = 32'h300B;
    #1 chkb("hz same word", sdIf.ld_hazard, 1'b1);
    tick();
    sdIf.ld_addr = 32'h300C;
    #1 chkb("hz next word", sdIf.ld_hazard, 1'b0);
    sdIf.ld_addr = 32'h300B;
    sdIf.m_ack = 1'b1;
    waitIdle("hz drain idle", 10);
    chkb("hz after retire", sdIf.ld_hazard, 1'b0);
    sdIf.m_ack = 1'b0;
    sdIf.ld_valid = 0;

    // Timeout: drop on 16th busy cycle, one-cycle bus_err
    for (int v = 0; v < 2; v++) begin
      tick();
      drv(32'h7000, 32'h0BADCAFE, 4'b1111);
      tick();
      sdIf.st_valid = 0;
      for (int k = 0; k < TIMEOUT; k++) begin
        tick();
        if (v == 1 && k == TIMEOUT - 1) sdIf.m_ack = 1'b1;
        #1 chkb("to m_req", sdIf.m_req, 1'b1);
        chkb("to bus_err early", sdIf.bus_err, 1'b0);
      end
      tick();
      sdIf.m_ack = 1'b0;
      #1 chkb(v == 0 ? "to bus_err pulse" : "to ack wins", sdIf.bus_err, v == 0);
      chkb("to idle", sdIf.idle, 1'b1);
      tick();
      #1 chkb("to bus_err one cycle", sdIf.bus_err, 1'b0);
    end

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      tick();
      drv(32'h8000 + 32'(i) * 4, 32'h5A5A0000 + 32'(i), 4'b1111);
    end
    tick();
    sdIf.st_valid = 0;
    #1 chkb("rd m_req before", sdIf.m_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 chkb("rd m_req async", sdIf.m_req, 1'b0);
    chkb("rd idle in reset", sdIf.idle, 1'b1);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chkb("rd no stale m_req", sdIf.m_req, 1'b0);
      chkb("rd idle", sdIf.idle, 1'b1);
      chkb("rd st_stall", sdIf.st_stall, 1'b0);
      tick();
    end

    chk("scoreboard empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/store_drain_ctrl.md
Name: store_drain_ctrl

Overview:
- Store-write controller between the M stage and the data-memory bus.
- Accepts committed stores (address, raw register data, 4-bit byte enable from the byte-enable decoder) into a small in-order queue.
- Drains the queue to memory over a req/ack handshake: lane-replicates data, stalls the pipeline when full, flags load/store word-address conflicts, and retires hung writes via a watchdog.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).
- TIMEOUT, 16, max BUSY cycles without ack before an entry is dropped; ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  store commit this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  raw rt register value, right-aligned.
- st_byteen  in  4  byte enables; 0000 = no write.
- st_stall  out  1  queue full; M stage must hold.
- ld_valid  in  1  load in M stage.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  a queued store hits the load's word address.
- m_req  out  1  write request to memory.
- m_addr  out  32  {head addr[31:2], 2'b00}.
- m_wdata  out  32  lane-replicated write data.
- m_byteen  out  4  head byte enables.
- m_ack  in  1  memory accepted the write this cycle.
- bus_err  out  1  one-cycle pulse when an entry is dropped by timeout.
- idle  out  1  queue empty and state IDLE (sync/eret barrier).

Behaviour:
- Reset (async assert, sync-free release): count=0, rd/wr ptr=0, state=IDLE, wait counter=0, bus_err=0. Combinational outputs follow from that: m_req=0, st_stall=0, ld_hazard=0, idle=1, m_addr/m_wdata/m_byteen=0.
- Reset asserted mid-transfer drops all queued stores and the in-flight request. m_req falls asynchronously.
- Push: when st_valid && st_byteen!=0 && !st_stall, the entry is written at wr_ptr on the rising edge; wr_ptr wraps modulo DEPTH.
  - st_valid with byteen 0000 is ignored.
  - Push while st_stall=1 is ignored; upstream must hold.
- st_stall = (count==DEPTH). It is combinational and does not consider a same-cycle pop, so a full queue stalls for one cycle even while draining.
- Data replication at push, chosen by st_byteen:
  - 1111: data as-is.
  - 0011 / 1100: {2{st_data[15:0]}}.
  - One-hot: {4{st_data[7:0]}}.
  - Any other pattern: data as-is, enables passed unchanged.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on the edge where count>0 (count sampled before that edge's push). A push into an empty queue at edge N therefore gives m_req=1 from after edge N+1.
  - BUSY: m_req=1, and m_addr/m_wdata/m_byteen come from the head, stable until retire.
  - Retire (head popped, wait counter cleared) when m_ack=1, or when the wait counter reaches TIMEOUT-1 with m_ack=0.
  - After retire, the next state is BUSY if count after the pop is >0, else IDLE. Back-to-back requests have zero bubble.
- Wait counter: increments each BUSY cycle without ack and clears on retire.
- Simultaneous events:
  - m_ack and timeout on the same edge: ack wins, no bus_err.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- bus_err is registered: high for exactly the one cycle after a timeout retire.
- ld_hazard is combinational: ld_valid && any valid entry (including the head in flight) has addr[31:2]==ld_addr[31:2]. It is 0 when the queue is empty.
- m_ack while IDLE is ignored.
- idle = (count==0) && state==IDLE.

Test Plan:
- sw to empty queue:
  - Stimulus: st_addr=0x1004, data=0xDEADBEEF, byteen=1111; hold m_ack=0 for 3 cycles, then ack.
  - Required: m_req rises 1 cycle after push, with m_addr=0x1004, m_wdata=0xDEADBEEF, m_byteen=1111 stable for 4 cycles; idle=1 the cycle after ack.
- sb/sh replication:
  - Stimulus: sb at 0x2003 with data 0x12345678, byteen=1000; then sh at 0x2002 with byteen=1100; m_ack tied high.
  - Required: m_wdata=0x78787878 with m_byteen=1000, then 0x56785678 with m_byteen=1100, on consecutive cycles.
- Full queue:
  - Stimulus: with m_ack=0, push 5 stores on consecutive cycles.
  - Required: st_stall=1 after the 4th push; the 5th is held; after one ack the 5th enters and order is preserved across pointer wrap.
- Load hazard:
  - Stimulus: queue a store to 0x3008; apply ld_addr=0x300B, then ld_addr=0x300C.
  - Required: ld_hazard=1 for 0x300B, 0 for 0x300C; 0 once the store retires.
- Timeout:
  - Stimulus: hold m_ack=0 with TIMEOUT=16.
  - Required: head dropped on the 16th BUSY cycle and bus_err high for exactly 1 cycle; with m_ack asserted on that same cycle instead, bus_err stays 0.
- Reset mid-drain:
  - Stimulus: 3 queued entries with m_req=1; pulse reset low.
  - Required: m_req=0 immediately; after release, idle=1, st_stall=0, and no stale request appears.
